// File: rtl/renkon_pkg.sv
// renkon shared package: layer/memory sizes, FSM states, word types.
// Also holds the saturate-then-ReLU helper used by every core.
package renkon_pkg;

  localparam int DWIDTH    = 16;
  localparam int FRACWIDTH = 8;
  localparam int LWIDTH    = 10;
  localparam int IMGSIZE   = 13;
  localparam int NETSIZE   = 12;
  localparam int CORE      = 8;
  localparam int CORELOG   = 3;
  localparam int FSIZE     = 5;
  localparam int PSIZE     = 2;
  localparam int AWIDTH    = 2 * DWIDTH + 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_BIAS,
    S_POOL,
    S_WRITE,
    S_DONE
  } state_t;

  typedef logic signed [DWIDTH-1:0] word_t;
  typedef logic [LWIDTH-1:0] cfg_t;

  // Negative clamps to 0 (ReLU after saturation), large clamps to max.
  function automatic word_t sat_relu(
    input logic signed [AWIDTH:0] v
  );
    word_t r;
    if (v[AWIDTH])
      r = '0;
    else if (|v[AWIDTH-1:DWIDTH-1])
      r = word_t'({1'b0, {(DWIDTH-1){1'b1}}});
    else
      r = v[DWIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/renkon_if.sv
// renkon host bus: memory load/readback ports, layer config, req/ack.
// master = host side, slave = accelerator side.
interface renkon_if;
  import renkon_pkg::*;

  logic               req;
  logic               img_we;
  logic [IMGSIZE-1:0] input_addr;
  logic [IMGSIZE-1:0] output_addr;
  word_t              write_img;
  logic [CORELOG:0]   net_we;
  logic [NETSIZE-1:0] net_addr;
  word_t              write_net;
  cfg_t               total_out;
  cfg_t               total_in;
  cfg_t               img_size;
  cfg_t               fil_size;
  cfg_t               pool_size;
  logic               ack;
  word_t              read_img;

  modport master (
    output req, img_we, input_addr, output_addr,
    output write_img, net_we, net_addr, write_net,
    output total_out, total_in, img_size,
    output fil_size, pool_size,
    input  ack, read_img
  );

  modport slave (
    input  req, img_we, input_addr, output_addr,
    input  write_img, net_we, net_addr, write_net,
    input  total_out, total_in, img_size,
    input  fil_size, pool_size,
    output ack, read_img
  );

endinterface

// File: rtl/renkon_core.sv
// renkon_core: one output-map lane -- weight memory, MAC, bias/sat/ReLU, pool max.
// Ports: host weight write, weight read addr, broadcast pixel, MAC/pool strobes, result.
module renkon_core
  import renkon_pkg::*;
#(
  parameter int ID = 0
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               idle,
  input  logic [CORELOG:0]   net_we,
  input  logic [NETSIZE-1:0] host_addr,
  input  word_t              write_net,
  input  logic [NETSIZE-1:0] rd_addr,
  input  word_t              pixel,
  input  logic               mac_en,
  input  logic               acc_clr,
  input  logic               pool_en,
  input  logic               pool_first,
  output word_t              result
);

  localparam logic [CORELOG:0] SEL =
    (CORELOG+1)'(ID + 1);

  word_t mem [2**NETSIZE];
  word_t w_q;

  logic signed [AWIDTH-1:0]   acc;
  logic signed [2*DWIDTH-1:0] prod;
  logic signed [AWIDTH:0]     sum;
  word_t                      cand;

  always_ff @(posedge clk)
    if (idle && net_we == SEL)
      mem[host_addr] <= write_net;

  always_ff @(posedge clk)
    w_q <= mem[rd_addr];

  assign prod = pixel * w_q;

  // During POOL, w_q holds the bias word fetched in BIAS.
  assign sum =
    {acc[AWIDTH-1], acc >>> FRACWIDTH} +
    {{(AWIDTH+1-DWIDTH){w_q[DWIDTH-1]}}, w_q};

  assign cand = sat_relu(sum);

  always_ff @(posedge clk) begin
    if (!xrst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (acc_clr)
        acc <= '0;
      else if (mac_en)
        acc <= acc +
          {{(AWIDTH-2*DWIDTH){prod[2*DWIDTH-1]}}, prod};
      // cand is >= 0, so loading it on the first
      // window position equals max(0, cand).
      if (pool_en && (pool_first || cand > result))
        result <= cand;
    end
  end

endmodule

// File: rtl/renkon_top.sv
// renkon_top: conv-layer accelerator -- image memory, loop FSM, CORE lanes, write-back.
// Ports: clk, xrst (sync active-low), bus (renkon_if.slave host interface).
module renkon_top
  import renkon_pkg::*;
(
  input  logic    clk,
  input  logic    xrst,
  renkon_if.slave bus
);

  state_t state;
  logic   ack_q;
  logic   mac_v;
  word_t  rd_q;

  word_t mem_i [2**IMGSIZE];

  cfg_t tout, tin, isz, fsz, psz;
  logic [IMGSIZE-1:0] ib, ob;
  logic [NETSIZE-1:0] nb;

  logic [31:0] isz2, fsz2, bias_off, wset, o2;
  cfg_t        osz, ngrp;

  cfg_t g, py, px, dy, dx, k, i, j;
  logic [CORELOG-1:0] wn;

  cfg_t        c_sz, o_sz_c;
  logic [31:0] f2_c;
  logic        bad;

  logic [31:0] row, col, map;
  logic [IMGSIZE-1:0] img_a, out_a, rd_addr, wa;
  logic [NETSIZE-1:0] w_a, w_rd;
  logic  we;
  word_t wd;
  word_t res [CORE];

  logic idle;
  assign idle = state == S_IDLE;

  assign c_sz   = (fsz > isz) ? '0 : isz - fsz + 1'b1;
  assign o_sz_c = (psz == '0) ? '0 : c_sz / psz;
  assign f2_c   = 32'(fsz) * 32'(fsz);
  assign bad    = o_sz_c == '0 || tout == '0 ||
                  tin == '0 || fsz == '0;

  assign row = 32'(py) * 32'(psz) + 32'(dy) + 32'(i);
  assign col = 32'(px) * 32'(psz) + 32'(dx) + 32'(j);

  assign img_a = IMGSIZE'(32'(ib) + 32'(k) * isz2 +
                          row * 32'(isz) + col);

  // The bias word follows the taps of each weight set.
  assign w_a = NETSIZE'(32'(nb) + 32'(g) * wset +
    ((state == S_BIAS) ? bias_off :
      32'(k) * fsz2 + 32'(i) * 32'(fsz) + 32'(j)));

  assign map   = 32'(g) * CORE + 32'(wn);
  assign out_a = IMGSIZE'(32'(ob) + map * o2 +
                          32'(py) * 32'(osz) + 32'(px));

  assign rd_addr = idle ? bus.input_addr : img_a;
  assign w_rd    = idle ? bus.net_addr : w_a;

  always_comb begin
    we = 1'b0;
    wa = bus.input_addr;
    wd = bus.write_img;
    if (state == S_WRITE) begin
      we = map < 32'(tout);
      wa = out_a;
      wd = res[wn];
    end else if (idle) begin
      we = bus.img_we;
    end
  end

  always_ff @(posedge clk)
    if (we)
      mem_i[wa] <= wd;

  always_ff @(posedge clk) begin
    if (!xrst)
      rd_q <= '0;
    else
      rd_q <= mem_i[rd_addr];
  end

  for (genvar n = 0; n < CORE; n++) begin : g_core
    renkon_core #(.ID(n)) u_core (
      .clk        (clk),
      .xrst       (xrst),
      .idle       (idle),
      .net_we     (bus.net_we),
      .host_addr  (bus.net_addr),
      .write_net  (bus.write_net),
      .rd_addr    (w_rd),
      .pixel      (rd_q),
      .mac_en     (mac_v),
      .acc_clr    (state == S_POOL ||
                   state == S_LOAD),
      .pool_en    (state == S_POOL),
      .pool_first (dy == '0 && dx == '0),
      .result     (res[n])
    );
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state    <= S_IDLE;
      ack_q    <= 1'b1;
      mac_v    <= 1'b0;
      tout     <= '0;
      tin      <= '0;
      isz      <= '0;
      fsz      <= '0;
      psz      <= '0;
      ib       <= '0;
      ob       <= '0;
      nb       <= '0;
      isz2     <= '0;
      fsz2     <= '0;
      bias_off <= '0;
      wset     <= '0;
      o2       <= '0;
      osz      <= '0;
      ngrp     <= '0;
      {g, py, px, dy, dx, k, i, j} <= '0;
      wn       <= '0;
    end else begin
      mac_v <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req) begin
            tout  <= bus.total_out;
            tin   <= bus.total_in;
            isz   <= bus.img_size;
            fsz   <= bus.fil_size;
            psz   <= bus.pool_size;
            ib    <= bus.input_addr;
            ob    <= bus.output_addr;
            nb    <= bus.net_addr;
            ack_q <= 1'b0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          isz2     <= 32'(isz) * 32'(isz);
          fsz2     <= f2_c;
          bias_off <= f2_c * 32'(tin);
          wset     <= f2_c * 32'(tin) + 32'd1;
          osz      <= o_sz_c;
          o2       <= 32'(o_sz_c) * 32'(o_sz_c);
          ngrp     <= cfg_t'((32'(tout) + CORE - 1)
                             >> CORELOG);
          {g, py, px, dy, dx, k, i, j} <= '0;
          wn       <= '0;
          state    <= bad ? S_DONE : S_MAC;
        end
        S_MAC: begin
          mac_v <= 1'b1;
          if (j == fsz - 1'b1) begin
            j <= '0;
            if (i == fsz - 1'b1) begin
              i <= '0;
              if (k == tin - 1'b1) begin
                k     <= '0;
                state <= S_BIAS;
              end else begin
                k <= k + 1'b1;
              end
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        S_BIAS: state <= S_POOL;
        S_POOL: begin
          state <= S_MAC;
          if (dx == psz - 1'b1) begin
            dx <= '0;
            if (dy == psz - 1'b1) begin
              dy    <= '0;
              wn    <= '0;
              state <= S_WRITE;
            end else begin
              dy <= dy + 1'b1;
            end
          end else begin
            dx <= dx + 1'b1;
          end
        end
        S_WRITE: begin
          wn <= wn + 1'b1;
          if (wn == CORELOG'(CORE - 1)) begin
            state <= S_MAC;
            if (px == osz - 1'b1) begin
              px <= '0;
              if (py == osz - 1'b1) begin
                py <= '0;
                if (g == ngrp - 1'b1) begin
                  g     <= '0;
                  state <= S_DONE;
                end else begin
                  g <= g + 1'b1;
                end
              end else begin
                py <= py + 1'b1;
              end
            end else begin
              px <= px + 1'b1;
            end
          end
        end
        S_DONE: begin
          ack_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.read_img = rd_q;

endmodule

// File: tb/tb_renkon_top.sv
// Directed bench for renkon_top: reset, memory round-trip, 1x1 layers,
// empty layer, partial group, multi-input layer vs. model, mid-run reset.
module tb_renkon_top;
  import renkon_pkg::*;

  logic clk  = 1'b0;
  logic xrst = 1'b0;
  always #5 clk = ~clk;

  renkon_if bus ();

  renkon_top dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  localparam int TIN = 3;
  localparam int TOUT = 9;
  localparam int ISZ = 12;
  localparam int FSZ = 5;
  localparam int PSZ = 2;
  localparam int OSZ = 4;
  localparam int OB  = 5000;
  localparam int SETW = FSZ * FSZ * TIN + 1;

  int img_m [TIN*ISZ*ISZ];
  int wt [CORE][2*SETW];
  int expv [TOUT*OSZ*OSZ];

  logic signed [31:0] r;
  int cyc;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic wimg(input int a, input int d);
    @(negedge clk);
    bus.img_we     = 1'b1;
    bus.input_addr = IMGSIZE'(a);
    bus.write_img  = DWIDTH'(d);
    @(negedge clk);
    bus.img_we = 1'b0;
  endtask

  task automatic wnet(input int n, input int a, input int d);
    @(negedge clk);
    bus.net_we    = (CORELOG+1)'(n + 1);
    bus.net_addr  = NETSIZE'(a);
    bus.write_net = DWIDTH'(d);
    @(negedge clk);
    bus.net_we = '0;
  endtask

  task automatic rimg(input int a,
                      output logic signed [31:0] d);
    @(negedge clk);
    bus.input_addr = IMGSIZE'(a);
    @(negedge clk);
    d = {{16{bus.read_img[15]}}, bus.read_img};
  endtask

  task automatic start(input int tin, input int tout,
                       input int isz, input int fsz,
                       input int psz, input int ob);
    bus.total_in    = LWIDTH'(tin);
    bus.total_out   = LWIDTH'(tout);
    bus.img_size    = LWIDTH'(isz);
    bus.fil_size    = LWIDTH'(fsz);
    bus.pool_size   = LWIDTH'(psz);
    bus.input_addr  = '0;
    bus.output_addr = IMGSIZE'(ob);
    bus.net_addr    = '0;
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    chk("ack_low_after_req", 32'(bus.ack), 0);
  endtask

  task automatic wait_ack(input int budget, output int c);
    c = 0;
    while (bus.ack !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("ack_done", 32'(bus.ack), 1);
  endtask

  task automatic build_model();
    longint acc;
    longint s;
    int mx, g, n, base;
    for (int m = 0; m < TOUT; m++) begin
      g = m / CORE;
      n = m % CORE;
      base = g * SETW;
      for (int py = 0; py < OSZ; py++)
        for (int px = 0; px < OSZ; px++) begin
          mx = 0;
          for (int dy = 0; dy < PSZ; dy++)
            for (int dx = 0; dx < PSZ; dx++) begin
              acc = 0;
              for (int kk = 0; kk < TIN; kk++)
                for (int ii = 0; ii < FSZ; ii++)
                  for (int jj = 0; jj < FSZ; jj++)
                    acc += longint'(img_m[kk*ISZ*ISZ +
                             (py*PSZ+dy+ii)*ISZ +
                             (px*PSZ+dx+jj)]) *
                           longint'(wt[n][base +
                             kk*FSZ*FSZ + ii*FSZ + jj]);
              s = (acc >>> 8) + longint'(wt[n][base + SETW - 1]);
              if (s > 32767) s = 32767;
              if (s < 0) s = 0;
              if (int'(s) > mx) mx = int'(s);
            end
          expv[m*OSZ*OSZ + py*OSZ + px] = mx;
        end
    end
  endtask

  initial begin
    bus.req = 1'b0;
    bus.img_we = 1'b0;
    bus.input_addr = '0;
    bus.output_addr = '0;
    bus.write_img = '0;
    bus.net_we = '0;
    bus.net_addr = '0;
    bus.write_net = '0;
    bus.total_out = '0;
    bus.total_in = '0;
    bus.img_size = '0;
    bus.fil_size = '0;
    bus.pool_size = '0;

    // Reset state
    @(negedge clk);
    chk("reset_ack", 32'(bus.ack), 1);
    chk("reset_read_img", 32'(bus.read_img), 0);
    xrst = 1'b1;

    // Memory round-trip
    wimg(7, 'h1234);
    rimg(7, r);
    chk("roundtrip_7", r, 'h1234);

    // 1x1 identity: max of {256,1280,-768->0,512}
    wimg(0, 256);
    wimg(1, 1280);
    wimg(2, -768);
    wimg(3, 512);
    wimg(100, 'h7FFF);
    wimg(101, 'h7FFF);
    wnet(0, 0, 256);
    wnet(0, 1, 0);
    start(1, 1, 2, 1, 2, 100);
    wait_ack(200, cyc);
    rimg(100, r);
    chk("identity_out", r, 1280);
    rimg(101, r);
    chk("identity_next_untouched", r, 'h7FFF);

    // ReLU with bias: 256*-1.0 + 0.5 = -0.5 -> 0
    for (int a = 0; a < 4; a++) wimg(a, 256);
    wimg(100, 'h7FFF);
    wnet(0, 0, -256);
    wnet(0, 1, 128);
    start(1, 1, 2, 1, 2, 100);
    wait_ack(200, cyc);
    rimg(100, r);
    chk("relu_out", r, 0);

    // Filter larger than image: no writes
    wimg(100, 'h7FFF);
    start(1, 1, 2, 3, 2, 100);
    wait_ack(20, cyc);
    rimg(100, r);
    chk("empty_layer_untouched", r, 'h7FFF);

    // Multi-input layer with a partial second group
    for (int a = 0; a < TIN*ISZ*ISZ; a++) begin
      img_m[a] = int'($urandom_range(1200)) - 600;
      wimg(a, img_m[a]);
    end
    for (int n = 0; n < CORE; n++)
      for (int a = 0; a < 2*SETW; a++) begin
        if (a % SETW == SETW - 1)
          wt[n][a] = int'($urandom_range(2000)) - 1000;
        else
          wt[n][a] = int'($urandom_range(400)) - 200;
        wnet(n, a, wt[n][a]);
      end
    for (int a = OB; a < OB + (TOUT+1)*OSZ*OSZ; a++)
      wimg(a, 'h7FFF);
    build_model();
    start(TIN, TOUT, ISZ, FSZ, PSZ, OB);
    wait_ack(20000, cyc);
    for (int a = 0; a < TOUT*OSZ*OSZ; a++) begin
      rimg(OB + a, r);
      chk($sformatf("layer_word_%0d", a), r, expv[a]);
    end
    for (int a = TOUT*OSZ*OSZ; a < (TOUT+1)*OSZ*OSZ; a++) begin
      rimg(OB + a, r);
      chk($sformatf("past_map8_%0d", a), r, 'h7FFF);
    end

    // Reset in the middle of a run
    start(TIN, TOUT, ISZ, FSZ, PSZ, OB);
    repeat (500) @(negedge clk);
    chk("busy_before_reset", 32'(bus.ack), 0);
    xrst = 1'b0;
    @(negedge clk);
    chk("ack_after_mid_reset", 32'(bus.ack), 1);
    xrst = 1'b1;
    wimg(9, -42);
    rimg(9, r);
    chk("roundtrip_after_reset", r, -42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
